aesl_deadlock_block_detector: RTL and testbench

Evaluation end of the kernel deadlock monitor: consumes the per-kernel AXI-stream block, instance idle and instance block vectors that the kernel monitor top assembles from the dataflow hierarchy. It decides whether the kernel is stalled, requires the stalled pattern to persist before flagging, and reports a registered `block` level, an entry pulse, a snapshot of the offending signals and a saturating event count. It sits between the monitor top's signal taps and the testbench's "find kernel block." reporting loop.

---
 rtl/aesl_deadlock_pkg.sv | 34 +++
 rtl/aesl_deadlock_block_detector_cond.sv | 38 +++
 rtl/aesl_deadlock_block_detector.sv | 172 +++++++++++++++++
 tb/tb_aesl_deadlock_block_detector.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/aesl_deadlock_pkg.sv
// Shared types and constants for the kernel deadlock block detector.
package aesl_deadlock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SUSPECT = 2'd1,
    BLOCKED = 2'd2
  } det_state_t;

  localparam int EVENT_CNT_W = 16;

  // Smallest width able to index 'value' distinct codes; never below 1.
  function automatic int clog2_f(input int value);
    int width;
    int span;
    width = 0;
    span  = 1;
    for (int i = 0; i < 32; i++) begin
      if (span < value) begin
        span  = span * 2;
        width = width + 1;
      end else begin
        span = span;
      end
    end
    if (width < 1) begin
      width = 1;
    end else begin
      width = width;
    end
    return width;
  endfunction

endpackage

// File: rtl/aesl_deadlock_block_detector_cond.sv
// Combinational stall evaluation: masks idle owners out of the raw block
// vectors and decides whether the running kernel looks stalled.
import aesl_deadlock_pkg::*;

module aesl_deadlock_cond #(
  parameter int NUM_AXIS = 1,
  parameter int NUM_BLK  = 3
) (
  input  logic [NUM_AXIS-1:0]         axis_block_sigs,
  input  logic [NUM_BLK+NUM_AXIS:0]   inst_idle_sigs,
  input  logic [NUM_BLK-1:0]          inst_block_sigs,
  output logic [NUM_AXIS-1:0]         axb,
  output logic [NUM_BLK-1:0]          ib,
  output logic                        cond,
  output logic [NUM_AXIS+NUM_BLK-1:0] sig
);

  logic [NUM_BLK-1:0]  inst_idle_s;
  logic [NUM_AXIS-1:0] owner_idle_s;
  logic                top_idle_s;
  logic                all_parked_s;

  // Split the idle vector and derive the effective block terms.
  always_comb begin
    inst_idle_s  = inst_idle_sigs[NUM_BLK-1:0];
    top_idle_s   = inst_idle_sigs[NUM_BLK];
    owner_idle_s = inst_idle_sigs[NUM_BLK+NUM_AXIS:NUM_BLK+1];

    axb = axis_block_sigs & ~owner_idle_s;
    ib  = inst_block_sigs & ~inst_idle_s;

    // Every instance must be either idle or waiting on something.
    all_parked_s = &(inst_idle_s | inst_block_sigs);
    cond         = ~top_idle_s & all_parked_s & ((|ib) | (|axb));
    sig          = {axb, ib};
  end

endmodule

// File: rtl/aesl_deadlock_block_detector.sv
// Deadlock detector FSM: requires a stable stall signature for PERSIST_CYCLES
// edges before flagging, then reports level, pulse, snapshots and event count.
import aesl_deadlock_pkg::*;

module aesl_deadlock_block_detector #(
  parameter int NUM_AXIS       = 1,
  parameter int NUM_BLK        = 3,
  parameter int PERSIST_CYCLES = 16
) (
  input  logic                      kernel_monitor_clock,
  input  logic                      kernel_monitor_reset,
  input  logic [NUM_AXIS-1:0]       axis_block_sigs,
  input  logic [NUM_BLK+NUM_AXIS:0] inst_idle_sigs,
  input  logic [NUM_BLK-1:0]        inst_block_sigs,
  output logic                      block,
  output logic                      block_pulse,
  output logic [NUM_BLK-1:0]        blk_snapshot,
  output logic [NUM_AXIS-1:0]       axis_snapshot,
  output logic [15:0]               event_count
);

  localparam int CNT_W = clog2_f(PERSIST_CYCLES + 1);
  localparam int SIG_W = NUM_AXIS + NUM_BLK;
  localparam logic [CNT_W-1:0]       CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]       CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]         PERSIST_TGT = (CNT_W+1)'(PERSIST_CYCLES);
  localparam logic [EVENT_CNT_W-1:0] EVENT_MAX   = {EVENT_CNT_W{1'b1}};
  localparam logic [EVENT_CNT_W-1:0] EVENT_ONE   = {{(EVENT_CNT_W-1){1'b0}}, 1'b1};

  logic [NUM_AXIS-1:0] axb_s;
  logic [NUM_BLK-1:0]  ib_s;
  logic                cond_s;
  logic [SIG_W-1:0]    sig_s;

  det_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W:0]      cnt_inc_s;
  logic                persist_met_s;
  logic [SIG_W-1:0]    sig_q, sig_d;
  logic                sig_changed_s;
  logic                enter_s;

  logic                   block_q, block_d;
  logic                   block_pulse_q, block_pulse_d;
  logic [NUM_BLK-1:0]     blk_snapshot_q, blk_snapshot_d;
  logic [NUM_AXIS-1:0]    axis_snapshot_q, axis_snapshot_d;
  logic [EVENT_CNT_W-1:0] event_count_q, event_count_d;

  aesl_deadlock_cond #(
    .NUM_AXIS (NUM_AXIS),
    .NUM_BLK  (NUM_BLK)
  ) u_cond (
    .axis_block_sigs (axis_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .inst_block_sigs (inst_block_sigs),
    .axb             (axb_s),
    .ib              (ib_s),
    .cond            (cond_s),
    .sig             (sig_s)
  );

  // Next-state, persistence counter and signature tracking.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sig_d         = sig_q;
    enter_s       = 1'b0;
    sig_changed_s = (sig_s != sig_q);
    cnt_inc_s     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    // Compared with >= so a restart inside SUSPECT still terminates when PERSIST_CYCLES is 1.
    persist_met_s = (cnt_inc_s >= PERSIST_TGT);

    case (state_q)
      RUN: begin
        if (cond_s) begin
          cnt_d = CNT_ONE;
          sig_d = sig_s;
          if (PERSIST_CYCLES == 1) begin
            state_d = BLOCKED;
            enter_s = 1'b1;
          end else begin
            state_d = SUSPECT;
          end
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      SUSPECT: begin
        if (!cond_s) begin
          state_d = RUN;
          cnt_d   = CNT_ZERO;
        end else if (sig_changed_s) begin
          cnt_d = CNT_ONE;
          sig_d = sig_s;
        end else if (persist_met_s) begin
          state_d = BLOCKED;
          cnt_d   = PERSIST_TGT[CNT_W-1:0];
          enter_s = 1'b1;
        end else begin
          cnt_d = cnt_inc_s[CNT_W-1:0];
        end
      end
      BLOCKED: begin
        if (!cond_s) begin
          state_d = RUN;
          cnt_d   = CNT_ZERO;
        end else if (sig_changed_s) begin
          state_d = SUSPECT;
          cnt_d   = CNT_ONE;
          sig_d   = sig_s;
        end else begin
          state_d = BLOCKED;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = CNT_ZERO;
        sig_d   = {SIG_W{1'b0}};
      end
    endcase
  end

  // Next values of the registered reporting outputs.
  always_comb begin
    block_d         = (state_d == BLOCKED);
    block_pulse_d   = enter_s;
    blk_snapshot_d  = blk_snapshot_q;
    axis_snapshot_d = axis_snapshot_q;
    event_count_d   = event_count_q;
    if (enter_s) begin
      blk_snapshot_d  = inst_block_sigs;
      axis_snapshot_d = axb_s;
      if (event_count_q != EVENT_MAX) begin
        event_count_d = event_count_q + EVENT_ONE;
      end else begin
        event_count_d = EVENT_MAX;
      end
    end else begin
      event_count_d = event_count_q;
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge kernel_monitor_clock or posedge kernel_monitor_reset) begin
    if (kernel_monitor_reset) begin
      state_q         <= RUN;
      cnt_q           <= CNT_ZERO;
      sig_q           <= {SIG_W{1'b0}};
      block_q         <= 1'b0;
      block_pulse_q   <= 1'b0;
      blk_snapshot_q  <= {NUM_BLK{1'b0}};
      axis_snapshot_q <= {NUM_AXIS{1'b0}};
      event_count_q   <= {EVENT_CNT_W{1'b0}};
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      sig_q           <= sig_d;
      block_q         <= block_d;
      block_pulse_q   <= block_pulse_d;
      blk_snapshot_q  <= blk_snapshot_d;
      axis_snapshot_q <= axis_snapshot_d;
      event_count_q   <= event_count_d;
    end
  end

  assign block         = block_q;
  assign block_pulse   = block_pulse_q;
  assign blk_snapshot  = blk_snapshot_q;
  assign axis_snapshot = axis_snapshot_q;
  assign event_count   = event_count_q;

endmodule

// File: tb/tb_aesl_deadlock_block_detector.sv
// Scoreboard bench for the deadlock detector (NUM_AXIS=1, NUM_BLK=3, PERSIST_CYCLES=16).
module tb_aesl_deadlock_block_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  axis_blk;
  logic [4:0]  idle;
  logic [2:0]  iblk;
  logic        block;
  logic        block_pulse;
  logic [2:0]  blk_snapshot;
  logic [0:0]  axis_snapshot;
  logic [15:0] event_count;

  typedef struct {
    logic [21:0] vec;
    string       name;
    int          edge_no;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        ex;
  logic [21:0] got;
  int          checks = 0;
  int          errors = 0;

  // Expected persistent outputs, maintained by the scenarios below.
  logic [2:0]  exp_bsnap;
  logic        exp_asnap;
  logic [15:0] exp_evc;

  always #5 clk = ~clk;

  aesl_deadlock_block_detector dut (
    .kernel_monitor_clock (clk),
    .kernel_monitor_reset (rst),
    .axis_block_sigs      (axis_blk),
    .inst_idle_sigs       (idle),
    .inst_block_sigs      (iblk),
    .block                (block),
    .block_pulse          (block_pulse),
    .blk_snapshot         (blk_snapshot),
    .axis_snapshot        (axis_snapshot),
    .event_count          (event_count)
  );

  function automatic exp_t mk(input logic b, input logic p, input string nm, input int e);
    exp_t r;
    r.vec     = {b, p, exp_bsnap, exp_asnap, exp_evc};
    r.name    = nm;
    r.edge_no = e;
    return r;
  endfunction

  task automatic drive(input logic a, input logic [4:0] id, input logic [2:0] bl);
    axis_blk = a;
    idle     = id;
    iblk     = bl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 5'b00000, 3'b000);
    exp_bsnap = 3'b000; exp_asnap = 1'b0; exp_evc = 16'd0;
    #3;
    sb_q.push_back(mk(1'b0, 1'b0, "reset", 0));
    got = {block, block_pulse, blk_snapshot, axis_snapshot, event_count};
    ex = sb_q.pop_front(); checks++;
    if (got !== ex.vec) begin
      errors++; $display("FAIL %s: got %h expected %h", ex.name, got, ex.vec);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_busy();
    drive(1'b0, 5'b00000, 3'b000);
    for (int e = 1; e <= 100; e++) begin
      sb_q.push_back(mk(1'b0, 1'b0, "busy", e));
      @(posedge clk); #1;
      got = {block, block_pulse, blk_snapshot, axis_snapshot, event_count};
      ex = sb_q.pop_front(); checks++;
      if (got !== ex.vec) begin
        errors++; $display("FAIL %s edge %0d: got %h expected %h", ex.name, ex.edge_no, got, ex.vec);
      end
    end
  endtask

  // Instance stall with idle[0]=idle[2]=1, running top, instance 1 blocked; then release.
  task automatic test_inst_stall();
    drive(1'b0, 5'b00101, 3'b010);
    for (int e = 1; e <= 21; e++) begin
      if (e == 21) drive(1'b0, 5'b00000, 3'b000);
      if (e == 16) begin exp_bsnap = 3'b010; exp_asnap = 1'b0; exp_evc = exp_evc + 16'd1; end
      sb_q.push_back(mk(e >= 16 && e <= 20, e == 16, "inst_stall", e));
      @(posedge clk); #1;
      got = {block, block_pulse, blk_snapshot, axis_snapshot, event_count};
      ex = sb_q.pop_front(); checks++;
      if (got !== ex.vec) begin
        errors++; $display("FAIL %s edge %0d: got %h expected %h", ex.name, ex.edge_no, got, ex.vec);
      end
    end
  endtask

  // Signature changes on edge 10 (instance 2 becomes busy-blocked): persistence restarts.
  task automatic test_sig_change();
    drive(1'b0, 5'b00101, 3'b010);
    for (int e = 1; e <= 29; e++) begin
      if (e == 10) drive(1'b0, 5'b00001, 3'b110);
      if (e == 29) drive(1'b0, 5'b00000, 3'b000);
      if (e == 25) begin exp_bsnap = 3'b110; exp_asnap = 1'b0; exp_evc = exp_evc + 16'd1; end
      sb_q.push_back(mk(e >= 25 && e <= 28, e == 25, "sig_change", e));
      @(posedge clk); #1;
      got = {block, block_pulse, blk_snapshot, axis_snapshot, event_count};
      ex = sb_q.pop_front(); checks++;
      if (got !== ex.vec) begin
        errors++; $display("FAIL %s edge %0d: got %h expected %h", ex.name, ex.edge_no, got, ex.vec);
      end
    end
  endtask

  // Stream-only stall with busy owner, then the same with an idle owner.
  task automatic test_axis_stall();
    drive(1'b1, 5'b00111, 3'b000);
    for (int e = 1; e <= 19; e++) begin
      if (e == 19) drive(1'b0, 5'b00000, 3'b000);
      if (e == 16) begin exp_bsnap = 3'b000; exp_asnap = 1'b1; exp_evc = exp_evc + 16'd1; end
      sb_q.push_back(mk(e >= 16 && e <= 18, e == 16, "axis_stall", e));
      @(posedge clk); #1;
      got = {block, block_pulse, blk_snapshot, axis_snapshot, event_count};
      ex = sb_q.pop_front(); checks++;
      if (got !== ex.vec) begin
        errors++; $display("FAIL %s edge %0d: got %h expected %h", ex.name, ex.edge_no, got, ex.vec);
      end
    end
    drive(1'b1, 5'b10111, 3'b000);
    for (int e = 1; e <= 30; e++) begin
      sb_q.push_back(mk(1'b0, 1'b0, "axis_owner_idle", e));
      @(posedge clk); #1;
      got = {block, block_pulse, blk_snapshot, axis_snapshot, event_count};
      ex = sb_q.pop_front(); checks++;
      if (got !== ex.vec) begin
        errors++; $display("FAIL %s edge %0d: got %h expected %h", ex.name, ex.edge_no, got, ex.vec);
      end
    end
    drive(1'b0, 5'b00000, 3'b000);
  endtask

  // Block, top goes idle for one edge, re-stall needs full persistence and counts again.
  task automatic test_back_to_back();
    drive(1'b0, 5'b00101, 3'b010);
    for (int e = 1; e <= 38; e++) begin
      if (e == 19) drive(1'b0, 5'b01101, 3'b010);
      if (e == 20) drive(1'b0, 5'b00101, 3'b010);
      if (e == 38) drive(1'b0, 5'b00000, 3'b000);
      if (e == 16 || e == 35) begin exp_bsnap = 3'b010; exp_asnap = 1'b0; exp_evc = exp_evc + 16'd1; end
      sb_q.push_back(mk((e >= 16 && e <= 18) || (e >= 35 && e <= 37), e == 16 || e == 35, "back_to_back", e));
      @(posedge clk); #1;
      got = {block, block_pulse, blk_snapshot, axis_snapshot, event_count};
      ex = sb_q.pop_front(); checks++;
      if (got !== ex.vec) begin
        errors++; $display("FAIL %s edge %0d: got %h expected %h", ex.name, ex.edge_no, got, ex.vec);
      end
    end
  endtask

  // Reset while counting (cnt=9) and while blocked; persistence restarts from scratch.
  task automatic test_reset_mid();
    drive(1'b0, 5'b00101, 3'b010);
    for (int e = 1; e <= 9; e++) begin
      sb_q.push_back(mk(1'b0, 1'b0, "suspect_pre_reset", e));
      @(posedge clk); #1;
      got = {block, block_pulse, blk_snapshot, axis_snapshot, event_count};
      ex = sb_q.pop_front(); checks++;
      if (got !== ex.vec) begin
        errors++; $display("FAIL %s edge %0d: got %h expected %h", ex.name, ex.edge_no, got, ex.vec);
      end
    end
    rst = 1'b1;
    exp_bsnap = 3'b000; exp_asnap = 1'b0; exp_evc = 16'd0;
    #2;
    sb_q.push_back(mk(1'b0, 1'b0, "reset_in_suspect", 0));
    got = {block, block_pulse, blk_snapshot, axis_snapshot, event_count};
    ex = sb_q.pop_front(); checks++;
    if (got !== ex.vec) begin
      errors++; $display("FAIL %s: got %h expected %h", ex.name, got, ex.vec);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int e = 1; e <= 18; e++) begin
      if (e == 16) begin exp_bsnap = 3'b010; exp_evc = exp_evc + 16'd1; end
      sb_q.push_back(mk(e >= 16, e == 16, "after_reset_stall", e));
      @(posedge clk); #1;
      got = {block, block_pulse, blk_snapshot, axis_snapshot, event_count};
      ex = sb_q.pop_front(); checks++;
      if (got !== ex.vec) begin
        errors++; $display("FAIL %s edge %0d: got %h expected %h", ex.name, ex.edge_no, got, ex.vec);
      end
    end
    rst = 1'b1;
    exp_bsnap = 3'b000; exp_asnap = 1'b0; exp_evc = 16'd0;
    #2;
    sb_q.push_back(mk(1'b0, 1'b0, "reset_in_blocked", 0));
    got = {block, block_pulse, blk_snapshot, axis_snapshot, event_count};
    ex = sb_q.pop_front(); checks++;
    if (got !== ex.vec) begin
      errors++; $display("FAIL %s: got %h expected %h", ex.name, got, ex.vec);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 5'b00000, 3'b000);
  endtask

  initial begin
    test_reset();
    test_busy();
    test_inst_stall();
    test_sig_change();
    test_axis_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
